// File: rtl/freq_bcd_conv_pkg.sv
// Shared constants and state encoding for the frequency-to-BCD converter.
package freq_pkg;

    localparam int unsigned DEF_FREQ_W    = 32;
    localparam int unsigned DEF_DIGITS    = 8;
    localparam int unsigned DEF_SAT_VALUE = 99999999;

    // One extra bit so the counter can hold FREQ_W itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEF_FREQ_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/freq_bcd_conv_if.sv
// Measurement-stage to display-driver bundle; master drives frequency, slave converts.
interface freq_bcd_conv_if #(
    parameter int unsigned FREQ_W = freq_pkg::DEF_FREQ_W,
    parameter int unsigned DIGITS = freq_pkg::DEF_DIGITS
);
    logic [FREQ_W-1:0]   frequency;
    logic                freq_valid;
    logic [4*DIGITS-1:0] bcd_out;
    logic                bcd_valid;
    logic                overflow;
    logic                busy;
    logic [DIGITS-1:0]   blank_mask;

    modport master (
        output frequency, freq_valid,
        input  bcd_out, bcd_valid, overflow, busy, blank_mask
    );

    modport slave (
        input  frequency, freq_valid,
        output bcd_out, bcd_valid, overflow, busy, blank_mask
    );
endinterface

// File: rtl/freq_bcd_conv_bcd_digit_adj.sv
// Double-dabble digit corrector: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj
);
    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/freq_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clk_10m cycle.
// Leading-zero blanking is built only when FREQ_BCD_BLANK_EN is defined.
module freq_bcd_conv
    import freq_pkg::*;
#(
    parameter int unsigned FREQ_W    = DEF_FREQ_W,
    parameter int unsigned DIGITS    = DEF_DIGITS,
    parameter int unsigned SAT_VALUE = DEF_SAT_VALUE
) (
    input logic            clk_10m,
    input logic            rst,
    freq_bcd_conv_if.slave bus
);
    localparam int unsigned         CW    = cnt_width(FREQ_W);
    localparam int unsigned         ACC_W = 4 * DIGITS;
    localparam logic [FREQ_W-1:0]   SAT   = FREQ_W'(SAT_VALUE);

    state_t             state, state_nxt;
    logic               fv_d1;
    logic               start;
    logic [FREQ_W-1:0]  bin, bin_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt, acc_adj;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               clamp, clamp_nxt;
    logic [ACC_W-1:0]   bcd_q, bcd_nxt;
    logic               ovf_q, ovf_nxt;
    logic               vld_q, vld_nxt;

    assign start = bus.freq_valid & ~fv_d1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (acc[4*g +: 4]),
            .adj   (acc_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk_10m) begin
        if (rst) begin
            state <= IDLE;
            fv_d1 <= 1'b0;
            bin   <= '0;
            acc   <= '0;
            cnt   <= '0;
            clamp <= 1'b0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            fv_d1 <= bus.freq_valid;
            bin   <= bin_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            clamp <= clamp_nxt;
            bcd_q <= bcd_nxt;
            ovf_q <= ovf_nxt;
            vld_q <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        clamp_nxt = clamp;
        bcd_nxt   = bcd_q;
        ovf_nxt   = ovf_q;
        vld_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clamp_nxt = (bus.frequency > SAT);
                    bin_nxt   = clamp_nxt ? SAT : bus.frequency;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Correction touches only the BCD half; the binary half shifts raw.
                {acc_nxt, bin_nxt} = {acc_adj, bin} << 1;
                cnt_nxt            = cnt + 1'b1;
                if (cnt == CW'(FREQ_W - 1)) state_nxt = DONE;
            end
            DONE: begin
                bcd_nxt   = acc;
                ovf_nxt   = clamp;
                vld_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.bcd_out   = bcd_q;
    assign bus.overflow  = ovf_q;
    assign bus.bcd_valid = vld_q;
    assign bus.busy      = (state != IDLE);

`ifdef FREQ_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_calc;
    logic              zero_run;

    // Digit 0 is never blanked so a zero reading still shows "0".
    always_comb begin
        blank_calc = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (acc[4*i +: 4] == 4'd0);
            blank_calc[i] = zero_run;
        end
    end

    always_ff @(posedge clk_10m) begin
        if (rst)                blank_q <= '0;
        else if (state == DONE) blank_q <= blank_calc;
    end

    assign bus.blank_mask = blank_q;
`else
    assign bus.blank_mask = '0;
`endif

endmodule

// File: tb/tb_freq_bcd_conv.sv
// Scoreboard bench for freq_bcd_conv: randomized and directed captures against a decimal reference model.
module tb_freq_bcd_conv;
    import freq_pkg::*;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  blank;
        int          due;
    } exp_t;

    logic clk_10m = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_cnt = 0;
    exp_t q[$];
    exp_t e_mon;
    exp_t last_e;

    always #5 clk_10m = ~clk_10m;
    always @(posedge clk_10m) cyc <= cyc + 1;

    freq_bcd_conv_if bus ();

    freq_bcd_conv dut (
        .clk_10m (clk_10m),
        .rst     (rst),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] f);
        exp_t        r;
        longint unsigned v;
        r.ovf   = (f > 32'd99999999);
        v       = r.ovf ? 64'd99999999 : {32'd0, f};
        r.blank = '0;
`ifdef FREQ_BCD_BLANK_EN
        for (int i = 1; i < 8; i++) r.blank[i] = (v < longint'(10) ** i);
`endif
        for (int i = 0; i < 8; i++) begin
            r.bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        r.due = 0;
        return r;
    endfunction

    // Monitor: every bcd_valid pulse must match the oldest outstanding capture.
    always @(negedge clk_10m) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.bcd_valid) begin
                check("pulse_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e_mon = q.pop_front();
                    check("bcd_out",    64'(bus.bcd_out),    64'(e_mon.bcd));
                    check("overflow",   64'(bus.overflow),   64'(e_mon.ovf));
                    check("blank_mask", 64'(bus.blank_mask), 64'(e_mon.blank));
                    check("latency",    64'(cyc),            64'(e_mon.due));
                    check("busy_at_valid", 64'(bus.busy),    64'd0);
                    check("busy_cycles", 64'(busy_cnt),      64'd33);
                    last_e = e_mon;
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic send(input logic [31:0] f, input int hold, input bit expect_out);
        exp_t e;
        @(posedge clk_10m); #1;
        bus.frequency  = f;
        bus.freq_valid = 1'b1;
        if (expect_out) begin
            e     = model(f);
            e.due = cyc + 34;
            q.push_back(e);
        end
        repeat (hold) @(posedge clk_10m);
        #1;
        bus.freq_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk_10m);
        check("drain_pending", 64'(q.size()), 64'd0);
        q.delete();
        repeat (2) @(posedge clk_10m);
        @(negedge clk_10m);
        check("bcd_hold", 64'(bus.bcd_out), 64'(last_e.bcd));
    endtask

    task automatic convert(input logic [31:0] f, input int hold);
        send(f, hold, 1'b1);
        drain();
    endtask

    initial begin
        rst            = 1'b1;
        bus.frequency  = '0;
        bus.freq_valid = 1'b0;
        last_e         = model(32'd0);
        repeat (3) @(posedge clk_10m);
        @(negedge clk_10m);
        check("rst_bcd_out",   64'(bus.bcd_out),    64'd0);
        check("rst_valid",     64'(bus.bcd_valid),  64'd0);
        check("rst_overflow",  64'(bus.overflow),   64'd0);
        check("rst_busy",      64'(bus.busy),       64'd0);
        check("rst_blank",     64'(bus.blank_mask), 64'd0);
        @(posedge clk_10m); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk_10m);

        convert(32'd1000000, 3);
        convert(32'd0, 2);
        convert(32'd1234, 5);
        convert(32'd99999999, 1);
        convert(32'd100000000, 4);
        convert(32'hFFFFFFFF, 2);
        convert(32'd9, 1);
        convert(32'd10, 40);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] f;
            case ($urandom_range(0, 3))
                0:       f = $urandom;
                1:       f = $urandom_range(0, 99999999);
                2:       f = $urandom_range(0, 9999);
                default: f = 32'd99999990 + $urandom_range(0, 20);
            endcase
            convert(f, $urandom_range(1, 50));
        end

        // Long level must produce exactly one conversion.
        convert(32'd4321, 20000);

        // Second rise ten cycles after the first is dropped.
        @(posedge clk_10m); #1;
        bus.frequency  = 32'd55555;
        bus.freq_valid = 1'b1;
        begin
            exp_t e;
            e     = model(32'd55555);
            e.due = cyc + 34;
            q.push_back(e);
        end
        repeat (3) @(posedge clk_10m); #1;
        bus.freq_valid = 1'b0;
        repeat (7) @(posedge clk_10m); #1;
        bus.frequency  = 32'd77777;
        bus.freq_valid = 1'b1;
        repeat (5) @(posedge clk_10m); #1;
        bus.freq_valid = 1'b0;
        drain();
        repeat (40) @(posedge clk_10m);

        // Reset in the middle of a conversion aborts it and clears outputs.
        convert(32'hFFFFFFFF, 2);
        send(32'd87654321, 2, 1'b0);
        repeat (13) @(posedge clk_10m); #1;
        rst = 1'b1;
        @(posedge clk_10m);
        @(negedge clk_10m);
        check("abort_busy",     64'(bus.busy),      64'd0);
        check("abort_bcd_out",  64'(bus.bcd_out),   64'd0);
        check("abort_overflow", 64'(bus.overflow),  64'd0);
        check("abort_valid",    64'(bus.bcd_valid), 64'd0);
        @(posedge clk_10m); #1;
        rst = 1'b0;
        last_e = model(32'd0);
        repeat (40) @(posedge clk_10m);
        @(negedge clk_10m);
        check("abort_bcd_stays", 64'(bus.bcd_out), 64'd0);
        convert(32'd12345678, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
